// File: rtl/comparator_pkg.sv
// Shared types and branch funct3 decode for the iterative magnitude comparator.
// Pure declarations and combinational helpers; no state.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // BLT/BGE compare signed; everything else (including reserved codes) unsigned.
    function automatic logic op_is_signed(input logic [2:0] op);
        return op[2] & ~op[1];
    endfunction

    function automatic logic branch_taken(input logic [2:0] op, input logic lt, input logic eq);
        logic t;
        t = 1'b0;
        case (op)
            F3_BEQ:           t = eq;
            F3_BNE:           t = ~eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = ~lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/chunk_comparator.sv
// Cascadable W-bit unsigned magnitude compare; a decided upstream result wins.
// Latency: combinational; backpressure: none.
module chunk_comparator #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         i_gt,
    input  logic         i_lt,
    input  logic         i_eq,
    output logic         gt,
    output logic         lt,
    output logic         eq
);

    assign gt = i_gt | (i_eq & (a > b));
    assign lt = i_lt | (i_eq & (a < b));
    assign eq = i_eq & (a == b);

endmodule

// File: rtl/iterative_comparator.sv
// MSB-first chunked comparator with branch decode; latency 1..N/CHUNK+1 cycles after accept.
// Accepts only in IDLE; holds results in DONE until out_ready.
module iterative_comparator
    import comparator_pkg::*;
#(
    parameter int N          = 64,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         gt,
    output logic         lt,
    output logic         eq,
    output logic         taken,
    output logic         busy
);

    localparam int NCH = N / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (N % CHUNK != 0) begin : g_bad_chunk
            $error("iterative_comparator: N must be a multiple of CHUNK");
        end
    endgenerate

    cmp_state_t state, state_nxt;

    // Element 0 of the packed chunk arrays is the most-significant chunk.
    logic [0:NCH-1][CHUNK-1:0] a_r, b_r;
    logic [IW-1:0]             idx;
    logic [2:0]                op_r;
    logic                      gt_r, lt_r, eq_r;

    logic c_gt, c_lt, c_eq;
    logic sign_split;
    logic chunk_diff;
    logic last_chunk;
    logic run_done;

    assign sign_split = op_is_signed(op) & (A[N-1] ^ B[N-1]);
    assign chunk_diff = (a_r[idx] != b_r[idx]);
    assign last_chunk = (idx == IW'(NCH - 1));
    assign run_done   = last_chunk | ((EARLY_EXIT != 0) & chunk_diff);

    chunk_comparator #(.W(CHUNK)) u_chunk (
        .a    (a_r[idx]),
        .b    (b_r[idx]),
        .i_gt (gt_r),
        .i_lt (lt_r),
        .i_eq (eq_r),
        .gt   (c_gt),
        .lt   (c_lt),
        .eq   (c_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = sign_split ? DONE : RUN;
            RUN:     if (run_done) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= '0;
            idx  <= '0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
            eq_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r  <= A;
                        b_r  <= B;
                        op_r <= op;
                        idx  <= '0;
                        // Differing sign bits settle a signed compare immediately.
                        if (sign_split) begin
                            gt_r <= ~A[N-1];
                            lt_r <= A[N-1];
                            eq_r <= 1'b0;
                        end else begin
                            gt_r <= 1'b0;
                            lt_r <= 1'b0;
                            eq_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    gt_r <= c_gt;
                    lt_r <= c_lt;
                    eq_r <= c_eq;
                    if (!run_done) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign gt        = out_valid & gt_r;
    assign lt        = out_valid & lt_r;
    assign eq        = out_valid & eq_r;
    assign taken     = out_valid & branch_taken(op_r, lt_r, eq_r);

endmodule
